// File: rtl/asfifo_wrctl_pkg.sv
// Shared definitions for the asynchronous FIFO read and write controllers:
// Gray/binary pointer conversion helpers and the synchroniser depth.
package asfifo_wrctl_pkg;

    localparam int ASFIFO_SYNC_STAGES = 2;
    localparam int PTR_MAX_W          = 32;

    // Binary to reflected Gray code; upper zero bits stay zero, so callers
    // can zero-extend any pointer width up to PTR_MAX_W and truncate back.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = '0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/asfifo_wrctl_sync2.sv
// Parameterised-width flop-chain synchroniser (two stages), shared by the
// read and write controllers of the asynchronous FIFO.
module asfifo_sync2
    import asfifo_wrctl_pkg::*;
#(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] stage [ASFIFO_SYNC_STAGES];

    // Shift the asynchronous input through the synchroniser flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ASFIFO_SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < ASFIFO_SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[ASFIFO_SYNC_STAGES-1];

endmodule

// File: rtl/asfifo_wrctl.sv
// Write-side control of the asynchronous FIFO: write pointer (binary and
// Gray), RAM write address, read-pointer synchronisation and registered
// full / almost_full / level status for the producer.
module asfifo_wrctl
    import asfifo_wrctl_pkg::*;
#(
    parameter int aw       = 2,
    parameter int af_level = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    output logic          ram_we,
    output logic [aw-1:0] waddr,
    output logic [aw:0]   wptr_gray,
    input  logic [aw:0]   rptr_gray_async,
    output logic          full,
    output logic          almost_full,
    output logic [aw:0]   level
);

    localparam int        PW    = aw + 1;
    localparam logic [aw:0] DEPTH = PW'(1 << aw);
    localparam logic [aw:0] AF    = PW'(af_level);

    logic [aw:0] wbin;
    logic [aw:0] rsync2;
    logic [aw:0] rbin;
    logic [aw:0] wnext;
    logic [aw:0] lvl;
    logic        acc;

    asfifo_sync2 #(.width(PW)) u_rsync (
        .clk (clk),
        .rst (rst),
        .d   (rptr_gray_async),
        .q   (rsync2)
    );

    // A write is taken only when not full and not in reset; full is a
    // register, so a write can never land on an already full FIFO.
    assign acc    = we & ~full & ~rst;
    assign ram_we = acc;
    assign waddr  = wbin[aw-1:0];

    // Level is computed from the synchronised (possibly stale) read pointer,
    // so it can only overstate occupancy.
    assign rbin  = PW'(gray2bin(PTR_MAX_W'(rsync2)));
    assign wnext = wbin + PW'(acc);
    assign lvl   = wnext - rbin;

    // Pointer advance and status registration.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            level       <= '0;
        end else begin
            if (acc) begin
                wbin      <= wnext;
                wptr_gray <= PW'(bin2gray(PTR_MAX_W'(wnext)));
            end
            level       <= lvl;
            full        <= (lvl == DEPTH);
            almost_full <= (lvl >= AF);
        end
    end

endmodule

// File: tb/tb_asfifo_wrctl.sv
// Scoreboard bench for asfifo_wrctl: the stimulus process keeps an integer
// occupancy model (total writes accepted, read count seen two edges late)
// and queues the expected response; a monitor process compares each cycle.
module tb_asfifo_wrctl;

    localparam int AW  = 2;
    localparam int AFL = 3;
    localparam int DEP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic          ram_we;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr_gray;
    logic [AW:0]   rptr_gray_async;
    logic          full;
    logic          almost_full;
    logic [AW:0]   level;

    asfifo_wrctl #(.aw(AW), .af_level(AFL)) dut (
        .clk             (clk),
        .rst             (rst),
        .we              (we),
        .ram_we          (ram_we),
        .waddr           (waddr),
        .wptr_gray       (wptr_gray),
        .rptr_gray_async (rptr_gray_async),
        .full            (full),
        .almost_full     (almost_full),
        .level           (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          ram_we;
        logic [AW-1:0] waddr;
        logic [AW:0] gray;
        bit          full;
        bit          af;
        logic [AW:0] level;
    } exp_t;

    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // Reference model state: counts are unbounded integers.
    int wcnt = 0;
    int rd   = 0;
    int rs1  = 0;
    int rs2  = 0;
    bit m_full = 0;

    function automatic logic [AW:0] gray_of(input int n);
        int m;
        m = n % (2 * DEP);
        return (AW+1)'(m ^ (m >> 1));
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus plus the expected response for that clock.
    task automatic step(input bit w, input bit r, input bit adv);
        exp_t e;
        int   lvl;
        @(negedge clk);
        if (r) rd = 0;
        else if (adv && rd < wcnt) rd++;
        we              = w;
        rst             = r;
        rptr_gray_async = gray_of(rd);
        e.rst    = r;
        e.ram_we = w && !m_full && !r;
        e.waddr  = AW'(wcnt % DEP);
        if (r) begin
            wcnt = 0; rs1 = 0; rs2 = 0; m_full = 0;
            e.level = '0; e.full = 0; e.af = 0;
        end else begin
            if (e.ram_we) wcnt++;
            lvl = wcnt - rs2;
            rs2 = rs1;
            rs1 = rd;
            m_full  = (lvl == DEP);
            e.level = (AW+1)'(lvl);
            e.full  = m_full;
            e.af    = (lvl >= AFL);
        end
        e.gray = gray_of(wcnt);
        exp_q.push_back(e);
    endtask

    // Direct post-edge check of a registered output.
    task automatic check_after_edge(input string name, input int req, input int sel);
        @(posedge clk);
        #2;
        case (sel)
            0: check(name, int'(level), req);
            1: check(name, int'(wptr_gray), req);
            default: check(name, int'(full), req);
        endcase
    endtask

    // Monitor: combinational outputs before the edge, registers after it.
    initial begin : monitor
        exp_t        e;
        logic [AW:0] prev_gray = '0;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                check("ram_we", int'(ram_we), int'(e.ram_we));
                if (!e.rst) check("waddr", int'(waddr), int'(e.waddr));
                @(posedge clk);
                #1;
                e = exp_q.pop_front();
                check("wptr_gray", int'(wptr_gray), int'(e.gray));
                check("level", int'(level), int'(e.level));
                check("full", int'(full), int'(e.full));
                check("almost_full", int'(almost_full), int'(e.af));
                if (!e.rst) check("gray_step_bits", ($countones(wptr_gray ^ prev_gray) <= 1) ? 1 : 0, 1);
                prev_gray = wptr_gray;
            end
        end
    end

    initial begin : stimulus
        int guard;
        we = 1'b0;
        rst = 1'b1;
        rptr_gray_async = '0;

        // Reset held two cycles with we high.
        step(1, 1, 0);
        step(1, 1, 0);

        // Fill with the read pointer parked at zero.
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        check_after_edge("fill_gray_hold", 6, 1);

        // Release one entry and observe the two-edge latency, then write.
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);

        // Alternate writes and read advances through a pointer wrap.
        for (int i = 0; i < 24; i++) step(i % 2 == 0, 0, i % 2 == 1);

        // Settle at level 2, then coincide a write with an rsync2 update.
        while (wcnt - rd > 2) step(0, 0, 1);
        while (wcnt - rd < 2) step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        check_after_edge("simul_level", 2, 0);

        // Reach level 3, pulse reset with we high, then write again.
        while (wcnt - rd < 3) step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(1, 1, 0);
        check_after_edge("midrst_level", 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0);
        end
        step(0, 0, 0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (exp_q.size() > 0) begin
            fails++;
            tests++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
